dec_skid_pipe: RTL and testbench

- Parametrised, registered successor to the team's combinational 4-to-10 active-low code decoder.
- Decodes a SEL_W-bit code into NUM_OUT one-hot-low (or one-hot-high) lines.
- Carries each code across a valid/ready interface through a 2-entry skid buffer, so back-pressure never drops or duplicates a code.
- Sits between a code producer (e.g. a select sequencer) and pad-level enable fan-out.

---
 rtl/dec_skid_pkg.sv | 28 ++
 rtl/dec_skid_buf.sv | 77 +++++++
 rtl/dec_skid_pipe.sv | 85 ++++++++
 tb/tb_dec_skid_pipe.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/dec_skid_pkg.sv
// Shared types and the code decoder for the registered select decoder pipeline.
package dec_skid_pkg;

  localparam int unsigned ERR_CNT_W = 8;
  localparam int unsigned DEC_MAX_W = 256;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } state_e;

  // Returns a DEC_MAX_W-wide word; callers keep the low num_out lines.
  // A code >= num_out leaves every line at the idle level.
  function automatic logic [DEC_MAX_W-1:0] decode_word(
    input logic [31:0] sel,
    input int unsigned num_out,
    input logic        active_low
  );
    logic [DEC_MAX_W-1:0] w;
    w = '0;
    for (int unsigned i = 0; i < DEC_MAX_W; i++) begin
      w[i] = (i < num_out) && (i == sel);
    end
    return active_low ? ~w : w;
  endfunction

endpackage

// File: rtl/dec_skid_buf.sv
// Generic 2-entry skid buffer (EMPTY/ONE/FULL) with registered ready/valid;
// the head shows IDLE whenever the buffer is empty.
module dec_skid_buf
  import dec_skid_pkg::*;
#(
  parameter type T    = logic,
  parameter T    IDLE = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  T     in_data,
  input  logic in_valid,
  output logic in_ready,
  output T     out_data,
  output logic out_valid,
  input  logic out_ready
);

  state_e state;
  T       skid;
  logic   accept;
  logic   pop;

  always_comb begin
    accept = in_valid & in_ready;
    pop    = out_valid & out_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_data  <= IDLE;
      skid      <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (accept && !pop) begin
            skid     <= in_data;
            in_ready <= 1'b0;
            state    <= FULL;
          end else if (pop && !accept) begin
            out_data  <= IDLE;
            out_valid <= 1'b0;
            state     <= EMPTY;
          end else if (pop && accept) begin
            out_data <= in_data;
          end
        end
        FULL: begin
          // in_ready is low here, so only a pop can move the state.
          if (pop) begin
            out_data <= skid;
            skid     <= IDLE;
            in_ready <= 1'b1;
            state    <= ONE;
          end
        end
        default: begin
          state     <= EMPTY;
          out_data  <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/dec_skid_pipe.sv
// Registered SEL_W-to-NUM_OUT decoder behind a 2-entry valid/ready skid buffer.
// Define DEC_ERR_CNT_EN to add err_cnt_pad, a saturating count of out-of-range codes.
module dec_skid_pipe
  import dec_skid_pkg::*;
#(
  parameter int SEL_W      = 4,
  parameter int NUM_OUT    = 10,
  parameter int ACTIVE_LOW = 1
) (
  input  logic               clk_pad,
  input  logic               rst_n_pad,
  input  logic [SEL_W-1:0]   sel_pad,
  input  logic               in_valid_pad,
  output logic               in_ready_pad,
  output logic [NUM_OUT-1:0] dec_pad,
  output logic               range_err_pad,
  output logic               out_valid_pad,
  input  logic               out_ready_pad
`ifdef DEC_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt_pad
`endif
);

  if (SEL_W < 1 || SEL_W > 16 || NUM_OUT < 1 || NUM_OUT > (1 << SEL_W) ||
      NUM_OUT > int'(DEC_MAX_W)) begin : g_bad_params
    $error("dec_skid_pipe: NUM_OUT must be in 1..2**SEL_W (SEL_W 1..16)");
  end

  typedef struct packed {
    logic [NUM_OUT-1:0] dec;
    logic               err;
  } entry_t;

  localparam logic [NUM_OUT-1:0] IDLE_DEC   = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam entry_t             IDLE_ENTRY = '{dec: IDLE_DEC, err: 1'b0};

  logic [31:0]          sel_ext;
  logic [DEC_MAX_W-1:0] dec_full;
  entry_t               in_entry;
  entry_t               head;

  // Decode happens at accept time so the stored entry is already pad-ready.
  always_comb begin
    sel_ext      = 32'(sel_pad);
    dec_full     = decode_word(sel_ext, NUM_OUT, ACTIVE_LOW != 0);
    in_entry.dec = dec_full[NUM_OUT-1:0];
    in_entry.err = (sel_ext >= 32'(NUM_OUT));
  end

  if (NUM_OUT < int'(DEC_MAX_W)) begin : g_unused
    logic unused_dec_hi;
    assign unused_dec_hi = ^dec_full[DEC_MAX_W-1:NUM_OUT];
  end

  dec_skid_buf #(
    .T    (entry_t),
    .IDLE (IDLE_ENTRY)
  ) u_buf (
    .clk       (clk_pad),
    .rst_n     (rst_n_pad),
    .in_data   (in_entry),
    .in_valid  (in_valid_pad),
    .in_ready  (in_ready_pad),
    .out_data  (head),
    .out_valid (out_valid_pad),
    .out_ready (out_ready_pad)
  );

  always_comb begin
    dec_pad       = head.dec;
    range_err_pad = head.err;
  end

`ifdef DEC_ERR_CNT_EN
  always_ff @(posedge clk_pad) begin
    if (!rst_n_pad) begin
      err_cnt_pad <= '0;
    end else if (in_valid_pad && in_ready_pad && in_entry.err && (err_cnt_pad != '1)) begin
      err_cnt_pad <= err_cnt_pad + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dec_skid_pipe.sv
// Randomized self-checking bench for dec_skid_pipe against a queue-based model.
module tb_dec_skid_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sel = '0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready;
  logic [9:0] dec;
  logic       range_err;
  logic       out_valid;

  logic [2:0] sel2 = '0;
  logic       in_valid2 = 1'b0;
  logic       out_ready2 = 1'b0;
  logic       in_ready2;
  logic [7:0] dec2;
  logic       range_err2;
  logic       out_valid2;

`ifdef DEC_ERR_CNT_EN
  logic [7:0] err_cnt;
  logic [7:0] err_cnt2;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int q[$];
  int exp_err = 0;

  always #5 clk = ~clk;

  dec_skid_pipe dut (
    .clk_pad       (clk),
    .rst_n_pad     (rst_n),
    .sel_pad       (sel),
    .in_valid_pad  (in_valid),
    .in_ready_pad  (in_ready),
    .dec_pad       (dec),
    .range_err_pad (range_err),
    .out_valid_pad (out_valid),
    .out_ready_pad (out_ready)
`ifdef DEC_ERR_CNT_EN
    ,
    .err_cnt_pad   (err_cnt)
`endif
  );

  dec_skid_pipe #(
    .SEL_W      (3),
    .NUM_OUT    (8),
    .ACTIVE_LOW (0)
  ) dut2 (
    .clk_pad       (clk),
    .rst_n_pad     (rst_n),
    .sel_pad       (sel2),
    .in_valid_pad  (in_valid2),
    .in_ready_pad  (in_ready2),
    .dec_pad       (dec2),
    .range_err_pad (range_err2),
    .out_valid_pad (out_valid2),
    .out_ready_pad (out_ready2)
`ifdef DEC_ERR_CNT_EN
    ,
    .err_cnt_pad   (err_cnt2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] exp_dec(input int s);
    if (s < 10) return ~(10'd1 << s);
    return 10'h3FF;
  endfunction

  // One clock: drive at negedge, compare against the model, then advance the model.
  task automatic step(input logic rst, input logic v, input logic [3:0] s, input logic r);
    logic acc;
    logic pp;
    @(negedge clk);
    rst_n = ~rst;
    in_valid = v;
    sel = s;
    out_ready = r;
    #1;
    check("out_valid", 32'(out_valid), 32'(q.size() > 0));
    check("in_ready", 32'(in_ready), 32'(q.size() < 2));
    check("dec", 32'(dec), 32'((q.size() > 0) ? exp_dec(q[0]) : 10'h3FF));
    check("range_err", 32'(range_err), 32'((q.size() > 0) ? (q[0] >= 10) : 1'b0));
`ifdef DEC_ERR_CNT_EN
    check("err_cnt", 32'(err_cnt), 32'(exp_err));
`endif
    @(posedge clk);
    if (rst) begin
      q.delete();
      exp_err = 0;
    end else begin
      acc = v && (q.size() < 2);
      pp  = (q.size() > 0) && r;
      if (pp) void'(q.pop_front());
      if (acc) begin
        q.push_back(int'(s));
        if (s >= 10 && exp_err < 255) exp_err++;
      end
    end
  endtask

  initial begin
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);

    // Stream 0..9 with out_ready held high.
    for (int i = 0; i < 10; i++) step(0, 1, 4'(i), 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    // Back-pressure: 3 then 5 must come out in order.
    step(0, 1, 3, 0);
    step(0, 1, 5, 0);
    step(0, 1, 9, 0);
    check("hold_dec3", 32'(dec), 32'(10'b1111110111));
    check("full_ready", 32'(in_ready), 32'(1'b0));
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    // Out-of-range codes.
    step(0, 1, 12, 1);
    step(0, 1, 15, 1);
    step(0, 0, 0, 1);
    check("oor_dec", 32'(dec), 32'(10'h3FF));
    check("oor_err", 32'(range_err), 32'(1'b1));
    step(0, 0, 0, 1);
`ifdef DEC_ERR_CNT_EN
    check("err_cnt2", 32'(err_cnt), 32'd2);
    for (int i = 0; i < 300; i++) step(0, 1, 4'(10 + (i % 6)), 1);
    step(0, 0, 0, 1);
    check("err_sat", 32'(err_cnt), 32'd255);
`endif

    // Reset while FULL.
    step(0, 1, 1, 0);
    step(0, 1, 2, 0);
    step(1, 1, 4, 1);
    step(0, 0, 0, 0);
    check("rst_valid", 32'(out_valid), 32'(1'b0));
    check("rst_dec", 32'(dec), 32'(10'h3FF));

    // Active-high, 3-bit instance.
    @(negedge clk);
    check("dut2_idle", 32'(dec2), 32'(8'h00));
    in_valid2 = 1'b1; sel2 = 3'd7; out_ready2 = 1'b1;
    @(negedge clk);
    sel2 = 3'd2;
    #1;
    check("dut2_sel7", 32'(dec2), 32'(8'b10000000));
    check("dut2_err", 32'(range_err2), 32'(1'b0));
    @(negedge clk);
    in_valid2 = 1'b0;
    #1;
    check("dut2_sel2", 32'(dec2), 32'(8'b00000100));
    @(negedge clk);
    #1;
    check("dut2_empty", 32'(out_valid2), 32'(1'b0));

    // Random valid/ready traffic.
    for (int i = 0; i < 10000; i++) begin
      step(0, $urandom_range(0, 99) < 70, 4'($urandom_range(0, 15)), $urandom_range(0, 99) < 60);
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
